// File: rtl/prism_pkg.sv
// Shared register map, field positions and event-word layout for the PRISM
// input conditioner.
package prism_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_EDGE   = 6'h04;
  localparam logic [5:0] ADDR_FIFO   = 6'h08;
  localparam logic [5:0] ADDR_STATUS = 6'h0C;
  localparam logic [5:0] ADDR_TS     = 6'h10;

  localparam int DEB_LEN_W      = 4;
  localparam int CTRL_EN_BIT    = 31;
  localparam int CTRL_FLUSH_BIT = 30;
  localparam int EDGE_FALL_LSB  = 8;
  localparam int ST_OVF_BIT     = 31;
  localparam int ST_DROP_BIT    = 30;

  typedef enum logic [1:0] {
    WR_32   = 2'b10,
    WR_NONE = 2'b11
  } wr_code_e;

  typedef struct packed {
    logic        valid;
    logic [7:0]  rsvd_hi;
    logic        rise;
    logic [2:0]  ch;
    logic [2:0]  rsvd_lo;
    logic [15:0] ts;
  } event_t;

  function automatic logic [31:0] make_event(input logic is_rise,
                                             input logic [2:0] chan,
                                             input logic [15:0] stamp);
    event_t ev;
    ev = '{valid: 1'b1, rsvd_hi: 8'h00, rise: is_rise, ch: chan,
           rsvd_lo: 3'h0, ts: stamp};
    return ev;
  endfunction

endpackage

// File: rtl/prism_debounce.sv
// Single-channel debouncer: cond follows raw once raw has differed from it
// for deb_len+1 consecutive samples.
module prism_debounce
  import prism_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 raw,
  input  logic [DEB_LEN_W-1:0] deb_len,
  output logic                 cond
);

  logic [DEB_LEN_W-1:0] cnt_reg;

  // >= guards against deb_len being lowered while a count is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      cond    <= 1'b0;
    end else if (raw == cond) begin
      cnt_reg <= '0;
    end else if (cnt_reg >= deb_len) begin
      cond    <= raw;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DEB_LEN_W'(1);
    end
  end

endmodule

// File: rtl/prism_in_cond.sv
// PRISM input conditioner: per-pin debounce, edge event logging with
// timestamps into a small FIFO, and a memory-mapped register window.
module prism_in_cond
  import prism_pkg::*;
#(
  parameter int NCH        = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] raw_in,
  input  logic [5:0]     address,
  input  logic [31:0]    data_in,
  input  logic [1:0]     data_write_n,
  input  logic [1:0]     data_read_n,
  output logic [31:0]    data_out,
  output logic           data_ready,
  output logic [NCH-1:0] cond_out,
  output logic           event_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DEB_LEN_W-1:0] deb_len_reg;
  logic                 en_reg;
  logic [NCH-1:0]       rise_mask_reg, fall_mask_reg;
  logic [NCH-1:0]       cond, cond_prev_reg, rise_det, fall_det, qual;
  logic [15:0]          ts_reg;
  logic [31:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 ovf_reg, drop_reg;
  logic                 wr, rd, flush, pop, full, push_ok, ovf_set, st_wr;
  logic                 ev_any, ev_multi, ev_rise;
  logic [2:0]           ev_ch;
  logic                 unused_data_bits;

  assign unused_data_bits = &{1'b0, data_in};

  for (genvar gi = 0; gi < NCH; gi++) begin : g_deb
    prism_debounce u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (raw_in[gi]),
      .deb_len (deb_len_reg),
      .cond    (cond[gi])
    );
  end

  assign cond_out   = cond;
  assign data_ready = 1'b1;
  assign event_irq  = (count_reg != '0) | ovf_reg;

  assign wr    = (data_write_n == WR_32);
  assign rd    = (data_read_n != 2'b11);
  assign flush = wr && (address == ADDR_CTRL) && data_in[CTRL_FLUSH_BIT];
  assign st_wr = wr && (address == ADDR_STATUS);
  assign pop   = rd && (address == ADDR_FIFO) && (count_reg != '0);
  assign full  = (count_reg == CW'(FIFO_DEPTH));

  // Transitions are seen the cycle after the debouncer updates cond.
  assign rise_det = cond & ~cond_prev_reg;
  assign fall_det = ~cond & cond_prev_reg;
  assign qual     = {NCH{en_reg}} & ((rise_det & rise_mask_reg) | (fall_det & fall_mask_reg));

  always_comb begin
    ev_any   = 1'b0;
    ev_multi = 1'b0;
    ev_rise  = 1'b0;
    ev_ch    = 3'h0;
    for (int c = 0; c < NCH; c++) begin
      if (qual[c]) begin
        if (ev_any) begin
          ev_multi = 1'b1;
        end else begin
          ev_any  = 1'b1;
          ev_ch   = 3'(c);
          ev_rise = rise_det[c];
        end
      end
    end
  end

  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign push_ok = ev_any && !flush && (!full || pop);
  assign ovf_set = ev_any && !flush && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_len_reg   <= '0;
      en_reg        <= 1'b0;
      rise_mask_reg <= '0;
      fall_mask_reg <= '0;
    end else if (wr) begin
      if (address == ADDR_CTRL) begin
        deb_len_reg <= data_in[DEB_LEN_W-1:0];
        en_reg      <= data_in[CTRL_EN_BIT];
      end
      if (address == ADDR_EDGE) begin
        rise_mask_reg <= data_in[NCH-1:0];
        fall_mask_reg <= data_in[EDGE_FALL_LSB +: NCH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_prev_reg <= '0;
      ts_reg        <= '0;
    end else begin
      cond_prev_reg <= cond;
      ts_reg        <= ts_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= make_event(ev_rise, ev_ch, ts_reg);
  end

  // Sticky set takes priority over a software clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg  <= 1'b0;
      drop_reg <= 1'b0;
    end else begin
      if (ovf_set)                            ovf_reg <= 1'b1;
      else if (st_wr && data_in[ST_OVF_BIT])  ovf_reg <= 1'b0;
      if (ev_multi)                           drop_reg <= 1'b1;
      else if (st_wr && data_in[ST_DROP_BIT]) drop_reg <= 1'b0;
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL: begin
        data_out[CTRL_EN_BIT]       = en_reg;
        data_out[DEB_LEN_W-1:0]     = deb_len_reg;
      end
      ADDR_EDGE: begin
        data_out[NCH-1:0]             = rise_mask_reg;
        data_out[EDGE_FALL_LSB +: NCH] = fall_mask_reg;
      end
      ADDR_FIFO: begin
        if (count_reg != '0) data_out = mem[rd_ptr_reg];
      end
      ADDR_STATUS: begin
        data_out[ST_OVF_BIT]  = ovf_reg;
        data_out[ST_DROP_BIT] = drop_reg;
        data_out[CW-1:0]      = count_reg;
      end
      ADDR_TS: data_out[15:0] = ts_reg;
      default: data_out = '0;
    endcase
  end

endmodule

// File: doc/prism_in_cond.md
PRISM_IN_COND -- requirements
Module: prism_in_cond

Interface
REQ-001 SHALL have parameter NCH, default 7, number of conditioned input channels.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two).
REQ-003 clk  input  1  project clock (64 MHz nominal); one clock domain.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 raw_in  input  NCH  pin inputs, already two-flop synchronised upstream.
REQ-006 address  input  6  register offset within the peripheral window.
REQ-007 data_in  input  32  write data.
REQ-008 data_write_n  input  2  11 = no write, 10 = 32-bit write; other codes are ignored.
REQ-009 data_read_n  input  2  11 = no read, any other code = read.
REQ-010 data_out  output  32  read data, combinational from address.
REQ-011 data_ready  output  1  constant 1.
REQ-012 cond_out  output  NCH  debounced inputs, fed to the PRISM in_data[6:0].
REQ-013 event_irq  output  1  high while FIFO is non-empty or overflow is set.

Function
REQ-014 Registers: 0x00 CTRL ([3:0] DEB_LEN, [31] EN); 0x04 EDGE ([NCH-1:0] rise mask, [NCH+7:8] fall mask); 0x08 FIFO pop; 0x0C STATUS; 0x10 TS; all other addresses read 0.
REQ-015 Per-channel debounce: raw == cond clears the counter; raw != cond increments it; when the counter equals DEB_LEN, the next edge updates cond and clears the counter.
REQ-016 DEB_LEN = 0 SHALL give cond = raw delayed by exactly 1 clock; DEB_LEN = N SHALL need N+1 consecutive differing samples.
REQ-017 Debounce SHALL run regardless of EN; EN gates event logging only.
REQ-018 Timestamp: 16-bit free-running counter, +1 per clock, wraps 0xFFFF->0x0000; a read of 0x10 returns {16'h0, ts}.
REQ-019 Event: a cond transition on channel c, with EN=1 and the matching rise/fall mask bit set, SHALL push {valid=1, 8'h0, edge(1=rise), channel[2:0], 3'h0, ts[15:0]} in the cycle after the cond update.
REQ-020 Simultaneous qualifying events: only the lowest channel index is pushed; others set the DROP sticky bit.
REQ-021 Push while full (no pop in the same cycle): the event is discarded and the OVF sticky bit is set.
REQ-022 A read at 0x08 returns the head entry combinationally and pops it at that clock edge; a read while empty returns 0 with no state change.
REQ-023 Push and pop in the same cycle SHALL both take effect, including when full; occupancy is unchanged.
REQ-024 STATUS read = {OVF[31], DROP[30], 27'h0, count[2:0]}; a 32-bit write to 0x0C with bit31/bit30 set clears OVF/DROP; the sticky set wins over a same-cycle clear.
REQ-025 Clearing EN does not flush the FIFO; writing CTRL bit 30 = 1 flushes it (count -> 0) in that cycle, and a same-cycle push is lost.
REQ-026 event_irq SHALL be registered-free: the combinational OR of (count != 0) and OVF.

Reset
REQ-027 rst_n low SHALL asynchronously clear: CTRL, EDGE, debounce counters, cond_out (all 0), ts, FIFO pointers/count, OVF, DROP.
REQ-028 Reset mid-debounce or mid-FIFO SHALL leave no residual event; the first event after release needs a full new qualification.

Structure
REQ-029 Register offsets, field positions and the event-word layout SHALL be constants in a shared package prism_pkg.
REQ-030 One sub-module, prism_debounce (a single channel with counter and cond flop), SHALL be instantiated NCH times; the FIFO SHALL be inline.

Verification
REQ-031 DEB_LEN=3, raw[2] goes high for 3 clocks then low -> cond_out[2] stays 0 and the FIFO stays empty.
REQ-032 DEB_LEN=3, EN=1, rise[2]=1, raw[2] held high -> cond_out[2] rises on the 4th clock; the 0x08 read gives valid=1, edge=1, ch=2, ts = the value at the push cycle.
REQ-033 raw[0] and raw[5] rise in the same cycle, with both enabled -> one entry for ch0, DROP=1.
REQ-034 Five events with no reads -> count=4, OVF=1, event_irq=1; four pops return events 1-4 in order; a fifth pop returns 0.
REQ-035 Full FIFO, pop and new event in the same cycle -> count stays 4, OVF stays 0.
REQ-036 ts at 0xFFFE, event pushed 2 clocks later -> logged ts=0x0000; rst_n pulsed mid-stream -> all registers read 0.
